bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequential controller that accepts a 14-bit unsigned binary value over a valid/ready handshake, converts it to four BCD digits with an iterative shift-and-add-3 datapath, and time-multiplexes the result onto a shared 7-segment driver. It sits between any binary-producing logic and the board's 4-digit display. It replaces per-digit combinational converters with one shared decoder driven by a digit scheduler.

## Interface
Parameters:
- SCAN_DIV, 4, clock cycles each digit stays enabled. Legal range is 1 or greater; set large on the board, small in simulation.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  input  1  the value on in_data is offered.
- in_data  input  14  unsigned binary value, 0..16383.
- in_ready  output  1  high only in IDLE. A transfer happens when in_valid and in_ready are both high at a rising edge.
- busy  output  1  high in CONV and COMMIT.
- bcd  output  16  displayed BCD value. Digit 3 is bits [15:12]; digit 0 is bits [3:0].
- ovf  output  1  the last committed value was greater than 9999.
- digit_en  output  4  one-hot, active-high digit select.
- seg  output  7  active-high segments. seg[0]=a through seg[6]=g.

## Operation
- The FSM has three states: IDLE, CONV and COMMIT.
- IDLE → CONV on a transfer.
  - Load a 30-bit shift register: {16'b0, in_data}.
  - Clear the iteration counter cnt (4-bit).
- CONV: each edge performs one iteration.
  - First, add 3 to every BCD nibble that is 5 or greater.
  - Then shift the whole register left by 1.
  - cnt increments each edge. The edge where cnt==13 moves the FSM to COMMIT, so CONV lasts exactly 14 edges.
- COMMIT: one edge, then → IDLE.
  - bcd ← shift register bits [29:14].
  - ovf ← (captured input > 9999). The captured input is held in a separate 14-bit register at acceptance.
- in_data and in_valid are ignored outside IDLE; no transfer can happen there.
- Scanner: free-running and independent of the FSM.
  - The prescaler counts 0..SCAN_DIV-1. On wrap, idx advances 0→1→2→3→0.
  - digit_en = 1<<idx.
  - With SCAN_DIV=1, idx advances every cycle.
- Segment patterns (hex, seg[6:0]):
  - Digits 0–9: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Blank=00, dash=40.
- seg shows the nibble of bcd selected by idx, registered together with digit_en so that both change on the same edge.
- Leading-zero blanking: digit k (k≥1) is blank when it and every higher digit are 0. Digit 0 is never blanked.
- When ovf=1, every digit shows dash (40) regardless of bcd. bcd still holds the truncated low 4 BCD digits.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, busy=0.
  - bcd=0000, ovf=0, cnt=0.
  - prescaler=0, idx=0, digit_en=0001, seg=3F.
- Reset asserted mid-conversion aborts the conversion. The display reverts to "0" and the value in flight is lost.
- Latency: the transfer edge is edge 0.
  - CONV occupies edges 1..14.
  - bcd and ovf update at edge 15.
  - in_ready rises after edge 15.
- Throughput: one value per 16 cycles when in_valid is held high.
- seg reflects a new bcd no later than the first scan edge after the commit. Between scan edges, seg may change only at the commit edge.
- Simultaneous events: a commit that coincides with a scan advance is legal. seg then uses the new idx and the new bcd on that same edge.
- The counter wrap-around rules are as listed in Operation (cnt 13→COMMIT; prescaler SCAN_DIV-1→0; idx 3→0).

## Test plan
- Reset release: after rst deasserts, check digit_en=0001, seg=3F, bcd=0000, in_ready=1. Over the next 4·SCAN_DIV cycles, digit_en cycles 0001→0010→0100→1000 and seg=00 on digits 1–3.
- Send 1234: bcd=1234 at edge 15 after the transfer. Digits 3..0 show 06, 5B, 4F, 66. busy is high for exactly 15 cycles.
- Send 7: bcd=0007. Digit 0 shows 07; digits 1–3 show 00. Send 1005: digit 3 shows 06, digits 2 and 1 show 3F, digit 0 shows 6D (inner zeros are not blanked).
- Send 9999, then 10000 back-to-back with in_valid held high:
  - The second transfer happens on the first cycle in_ready is high again.
  - After 9999: ovf=0, display 6F ×4.
  - After 10000: ovf=1, all digits show 40.
- Change in_data to 4321 during CONV with in_valid high: the conversion in progress still commits 1234. Then 4321 is accepted at the next IDLE.
- Assert rst at CONV edge 7: state returns to IDLE, bcd=0000, in_ready=1. No commit occurs after rst is released.

Source files
------------

// File: rtl/bcd_display_ctrl_if.sv
// Input handshake, conversion status and 7-segment drive of bcd_display_ctrl.
// The controller takes the slave side; the producer/board side takes master.
interface bcd_display_ctrl_if;
    logic        in_valid;
    logic [13:0] in_data;
    logic        in_ready;
    logic        busy;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  digit_en;
    logic [6:0]  seg;

    modport master (
        output in_valid, in_data,
        input  in_ready, busy, bcd, ovf, digit_en, seg
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, busy, bcd, ovf, digit_en, seg
    );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD converter (iterative shift-and-add-3) feeding a time-multiplexed
// 4-digit 7-segment display with leading-zero blanking and overflow dashes.
module bcd_display_ctrl #(
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_display_ctrl_if.slave bus
);
    localparam int NUM_DIG = 4;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [29:0]   sh_q, sh_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [13:0]   cap_q, cap_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    digit_en_q, digit_en_d;
    logic [6:0]    seg_q, seg_d;
    logic [29:0]   adj;
    logic [NUM_DIG-1:0] blank_d;
    logic [3:0]    nib_d;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0: seg_lut = 7'h3F;
            4'd1: seg_lut = 7'h06;
            4'd2: seg_lut = 7'h5B;
            4'd3: seg_lut = 7'h4F;
            4'd4: seg_lut = 7'h66;
            4'd5: seg_lut = 7'h6D;
            4'd6: seg_lut = 7'h7D;
            4'd7: seg_lut = 7'h07;
            4'd8: seg_lut = 7'h7F;
            4'd9: seg_lut = 7'h6F;
            default: seg_lut = 7'h00;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift; binary part passes through.
    assign adj[13:0] = sh_q[13:0];
    for (genvar k = 0; k < NUM_DIG; k++) begin : g_adj
        logic [3:0] nib;
        assign nib = sh_q[14+4*k +: 4];
        assign adj[14+4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = CONV;
                sh_d    = {16'b0, bus.in_data};
                cnt_d   = 4'd0;
                cap_d   = bus.in_data;
            end
            CONV: begin
                sh_d  = {adj[28:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = COMMIT;
            end
            COMMIT: begin
                bcd_d   = sh_q[29:14];
                ovf_d   = cap_q > 14'd9999;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display is decoded from next-state bcd/ovf/idx so seg and digit_en move together,
    // including a commit that lands on a scan advance.
    always_comb begin
        presc_d    = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        idx_d      = (presc_q == PRESC_MAX) ? idx_q + 2'd1 : idx_q;
        digit_en_d = 4'b0001 << idx_d;
        blank_d[3] = (bcd_d[15:12] == 4'd0);
        blank_d[2] = blank_d[3] && (bcd_d[11:8] == 4'd0);
        blank_d[1] = blank_d[2] && (bcd_d[7:4] == 4'd0);
        blank_d[0] = 1'b0;
        nib_d      = bcd_d[{idx_d, 2'b00} +: 4];
        if (ovf_d)               seg_d = 7'h40;
        else if (blank_d[idx_d]) seg_d = 7'h00;
        else                     seg_d = seg_lut(nib_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            digit_en_q <= 4'b0001;
            seg_q      <= 7'h3F;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            digit_en_q <= digit_en_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q == CONV) || (state_q == COMMIT);
    assign bus.bcd      = bcd_q;
    assign bus.ovf      = ovf_q;
    assign bus.digit_en = digit_en_q;
    assign bus.seg      = seg_q;
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: decimal reference model, scenario tasks,
// randomized values, display scan sampled over full refresh frames.
module tb_bcd_display_ctrl;
    localparam int SCAN_DIV = 4;
    localparam int SCAN_LEN = 4 * SCAN_DIV;
    localparam logic [9:0][6:0] LUT = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                       7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    bcd_display_ctrl_if bus ();
    bcd_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Edges since reset release; expected digit index is (cyc / SCAN_DIV) % 4.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    function automatic logic [15:0] exp_bcd(input int v);
        int t;
        logic [15:0] r;
        t = v % 10000;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p;
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (v > 9999) return 7'h40;
        if (k > 0 && v < p) return 7'h00;
        return LUT[(v / p) % 10];
    endfunction

    task automatic scan(output logic [3:0][6:0] s, output bit en_ok);
        int e;
        en_ok = 1'b1;
        s = '0;
        repeat (SCAN_LEN) begin
            @(posedge clk); #1;
            e = (cyc / SCAN_DIV) % 4;
            if (bus.digit_en !== 4'(1 << e)) en_ok = 1'b0;
            s[e] = bus.seg;
        end
    endtask

    task automatic send(input int v, output bit ok);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        ok = (bus.in_ready === 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 14'(v);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy !== 1'b0 && n < 64) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset();
        logic [3:0][6:0] s;
        bit en_ok;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_chk += 6;
        if (bus.digit_en !== 4'b0001) begin n_fail++; $display("FAIL rst_digit_en got %b want 0001", bus.digit_en); end
        if (bus.seg !== 7'h3F) begin n_fail++; $display("FAIL rst_seg got %h want 3f", bus.seg); end
        if (bus.bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_bcd got %h want 0000", bus.bcd); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", bus.ovf); end
        scan(s, en_ok);
        n_chk++;
        if (!en_ok) begin n_fail++; $display("FAIL rst_scan_order got bad digit_en want rotating one-hot"); end
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (s[k] !== exp_seg(0, k)) begin n_fail++; $display("FAIL rst_digit%0d got %h want %h", k, s[k], exp_seg(0, k)); end
        end
    endtask

    task automatic test_latency();
        bit ok;
        int n;
        logic [15:0] b14;
        logic [3:0][6:0] s;
        bit en_ok;
        send(1234, ok);
        n_chk += 3;
        if (!ok) begin n_fail++; $display("FAIL lat_ready got 0 want 1"); end
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy0 got %b want 1", bus.busy); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL lat_ready0 got %b want 0", bus.in_ready); end
        n = 0;
        b14 = 'x;
        while (bus.busy === 1'b1 && n < 64) begin
            @(posedge clk); #1; n++;
            if (n == 14) b14 = bus.bcd;
        end
        n_chk += 5;
        if (n != 15) begin n_fail++; $display("FAIL lat_busy_len got %0d want 15", n); end
        if (b14 !== 16'h0000) begin n_fail++; $display("FAIL lat_early_bcd got %h want 0000", b14); end
        if (bus.bcd !== exp_bcd(1234)) begin n_fail++; $display("FAIL lat_bcd got %h want %h", bus.bcd, exp_bcd(1234)); end
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL lat_ovf got %b want 0", bus.ovf); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready_after got %b want 1", bus.in_ready); end
        scan(s, en_ok);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (s[k] !== exp_seg(1234, k)) begin n_fail++; $display("FAIL lat_digit%0d got %h want %h", k, s[k], exp_seg(1234, k)); end
        end
    endtask

    task automatic test_convert();
        int vals[$] = '{7, 1005, 9999, 0, 16383, 10000, 9998, 80};
        bit ok;
        bit en_ok;
        int n;
        logic [3:0][6:0] s;
        repeat (6) vals.push_back(int'($urandom_range(0, 16383)));
        foreach (vals[i]) begin
            send(vals[i], ok);
            wait_idle(n);
            n_chk += 4;
            if (!ok || n >= 64) begin n_fail++; $display("FAIL conv_handshake v=%0d got ok=%0d n=%0d want 1/15", vals[i], ok, n); end
            if (bus.bcd !== exp_bcd(vals[i])) begin n_fail++; $display("FAIL conv_bcd v=%0d got %h want %h", vals[i], bus.bcd, exp_bcd(vals[i])); end
            if (bus.ovf !== (vals[i] > 9999)) begin n_fail++; $display("FAIL conv_ovf v=%0d got %b want %b", vals[i], bus.ovf, vals[i] > 9999); end
            scan(s, en_ok);
            if (!en_ok) begin n_fail++; $display("FAIL conv_scan v=%0d got bad digit_en want rotating one-hot", vals[i]); end
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (s[k] !== exp_seg(vals[i], k)) begin n_fail++; $display("FAIL conv_digit%0d v=%0d got %h want %h", k, vals[i], s[k], exp_seg(vals[i], k)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit en_ok;
        logic [3:0][6:0] s;
        bus.in_valid = 1'b1;
        bus.in_data  = 14'd9999;
        @(posedge clk); #1;
        bus.in_data = 14'd10000;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        n_chk += 3;
        if (n != 15) begin n_fail++; $display("FAIL b2b_gap got %0d want 15", n); end
        if (bus.bcd !== exp_bcd(9999)) begin n_fail++; $display("FAIL b2b_bcd1 got %h want %h", bus.bcd, exp_bcd(9999)); end
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf1 got %b want 0", bus.ovf); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_take got %b want 1", bus.busy); end
        wait_idle(n);
        n_chk += 2;
        if (bus.bcd !== exp_bcd(10000)) begin n_fail++; $display("FAIL b2b_bcd2 got %h want %h", bus.bcd, exp_bcd(10000)); end
        if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf2 got %b want 1", bus.ovf); end
        scan(s, en_ok);
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (s[k] !== 7'h40) begin n_fail++; $display("FAIL b2b_dash%0d got %h want 40", k, s[k]); end
        end
    endtask

    task automatic test_data_change();
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = 14'd1234;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1 bus.in_data = 14'd4321;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        n_chk += 2;
        if (bus.bcd !== exp_bcd(1234)) begin n_fail++; $display("FAIL chg_first got %h want %h", bus.bcd, exp_bcd(1234)); end
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL chg_ovf got %b want 0", bus.ovf); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL chg_take got %b want 1", bus.busy); end
        wait_idle(n);
        n_chk++;
        if (bus.bcd !== exp_bcd(4321)) begin n_fail++; $display("FAIL chg_second got %h want %h", bus.bcd, exp_bcd(4321)); end
    endtask

    task automatic test_reset_midconv();
        bit ok;
        send(5678, ok);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_chk += 3;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", bus.busy); end
        if (bus.bcd !== 16'h0000) begin n_fail++; $display("FAIL mid_bcd got %h want 0000", bus.bcd); end
        @(posedge clk); #1 rst = 1'b0;
        n_chk += 2;
        if (bus.seg !== 7'h3F) begin n_fail++; $display("FAIL mid_seg got %h want 3f", bus.seg); end
        if (bus.digit_en !== 4'b0001) begin n_fail++; $display("FAIL mid_digit_en got %b want 0001", bus.digit_en); end
        repeat (20) @(posedge clk);
        #1;
        n_chk += 2;
        if (bus.bcd !== 16'h0000) begin n_fail++; $display("FAIL mid_no_commit got %h want 0000", bus.bcd); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle got %b want 0", bus.busy); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_convert();
        test_back_to_back();
        test_data_change();
        test_reset_midconv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
